dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Word-access controller and two-port arbiter in front of the byte-wide data memory of the MIPS datapath. It accepts 32-bit load/store requests from the CPU memory stage and from the debug/loader port, and grants them round-robin. It sequences each word as four big-endian byte accesses on a single-port synchronous byte RAM, then returns a one-cycle completion pulse to the requester it served.

## Interface
- ADDR_W, 10, byte-address width of the data RAM (1024 bytes)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU request; held high with fields stable until cpu_done
- cpu_we  in  1  1 = store word, 0 = load word
- cpu_addr  in  32  byte address; bits [1:0] must be 00
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data; valid from cpu_done, held until next CPU load completes
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  high with cpu_done when the request was misaligned
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_done, dbg_err: same as the cpu_* ports, for the debug/loader requester
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM byte write enable (qualified by mem_en)
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  8  RAM write byte
- mem_rdata  in  8  RAM read byte; valid the cycle after the addressing cycle
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCESS (2-bit byte counter cnt 0..3), RDLAST, DONE.
- IDLE: if any req is high, latch the winner's id, we, addr and wdata, then go to ACCESS with cnt=0. If none is high, stay in IDLE.
- Arbitration:
  - A single requester wins outright.
  - If both requesters are high, the grant goes to the one not granted last.
  - The last-granted register resets to dbg, so the CPU wins the first tie.
- Misaligned request (addr[1:0] != 0): IDLE goes to DONE directly with err set. There is no RAM access, and rdata is unchanged.
- ACCESS:
  - Drive mem_en=1, mem_we=we, mem_addr={addr[ADDR_W-1:2], cnt}.
  - mem_wdata carries byte cnt of wdata: cnt0→[31:24], cnt1→[23:16], cnt2→[15:8], cnt3→[7:0].
  - cnt increments each cycle.
  - After cnt=3: a store goes to DONE, a load goes to RDLAST.
- Load capture: mem_rdata arriving one cycle after byte k is addressed is written into the winner's rdata lane k, using the same lane mapping as mem_wdata.
- RDLAST: mem_en=0; captures byte 3; goes to DONE.
- DONE: asserts the winner's done (and err if flagged), updates last-granted, and returns to IDLE.
- Address bits above ADDR_W-1 are ignored, so addresses wrap modulo 2^ADDR_W.
- Requester-side req changes after acceptance are ignored. The latched transaction always completes.
- The non-winning requester keeps its req high and is served next. There is no starvation: a tie is always granted alternately.

## Timing
- Reset (rst=0 at an edge), on the following cycle:
  - state=IDLE, cnt=0, last-granted=dbg.
  - All outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, busy, both done, both err, both rdata.
- Reset mid-transaction: the transaction is aborted. mem_en and mem_we are low from the next cycle. No done pulse is issued. Bytes already written stay written.
- Cycle numbering: C0 is the IDLE cycle in which req is sampled.
  - Bytes 0..3 are addressed in C1..C4.
  - Load bytes 0..3 are captured at the end of C2..C5.
- Store: done pulses in C5. Occupancy is 6 cycles including IDLE.
- Load: done pulses in C6, with rdata complete in that same cycle. Occupancy is 7 cycles.
- Misaligned request: done and err pulse in C1.
- Requesters using registered logic drop req in the cycle after done. The IDLE cycle following DONE therefore never re-accepts a completed request.
- The done and err outputs are decoded from registered state and are glitch-free.

## Test plan
- Reset then CPU store: addr 0x10, wdata 0xDEADBEEF → RAM bytes 0x10..0x13 = DE,AD,BE,EF; cpu_done in C5; busy high C1–C5.
- CPU load from 0x10 after that store → cpu_rdata = 0xDEADBEEF with cpu_done in C6; dbg_done stays 0.
- Both requesters raise req in the same cycle, held high for 3 transactions each → grants go CPU, DBG, CPU, DBG, ...
- Misaligned dbg load: addr 0x22 → dbg_done and dbg_err high in C1; mem_en never asserted; dbg_rdata unchanged.
- Store with addr 0x0000_0404 (ADDR_W=10) → writes RAM bytes 0x004..0x007.
- rst driven low in C3 of a store → no done pulse; mem_we low from C4; state IDLE; all outputs zero.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two word requesters (cpu, dbg) on one side,
// the single-port byte RAM plus a busy flag on the other.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [31:0]       dbg_rdata;
  logic              dbg_done;
  logic              dbg_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  // Arbiter side: accepts requests, drives the RAM.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done, dbg_err,
    output mem_en, mem_we, mem_addr, mem_wdata, busy,
    input  mem_rdata
  );

  // Environment side: requesters and the RAM model.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done, dbg_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for cpu/dbg word requests, sequencing each word as four
// big-endian byte accesses on a single-port synchronous byte RAM.
module dmem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDLAST, S_DONE} state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic              r_last_dbg;
  logic              r_id;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-3:0] r_word;
  logic [31:0]       r_wdata;
  logic [31:0]       r_cpu_rdata;
  logic [31:0]       r_dbg_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_done;
  logic              r_cpu_err;
  logic              r_dbg_done;
  logic              r_dbg_err;

  logic              w_any_req;
  logic              w_gnt_dbg;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic              w_misaligned;
  logic [1:0]        w_cnt_inc;
  logic              w_cap;
  logic [1:0]        w_lane;
  logic [4:0]        w_shift;
  logic [7:0]        w_wbyte [4];
  logic              w_unused_addr_hi;

  // On a tie the requester not served last wins.
  assign w_any_req    = bus.cpu_req | bus.dbg_req;
  assign w_gnt_dbg    = bus.dbg_req & (~bus.cpu_req | ~r_last_dbg);
  assign w_we         = w_gnt_dbg ? bus.dbg_we    : bus.cpu_we;
  assign w_addr       = w_gnt_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign w_wdata      = w_gnt_dbg ? bus.dbg_wdata : bus.cpu_wdata;
  assign w_misaligned = (w_addr[1:0] != 2'b00);
  assign w_cnt_inc    = r_cnt + 2'd1;
  assign w_unused_addr_hi = ^w_addr[31:ADDR_W];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wbyte[gi] = r_wdata[31-8*gi -: 8];
    end
  endgenerate

  // Read data lags its addressing cycle by one, so capture lane cnt-1.
  assign w_cap   = ~r_we & (((r_state == S_ACCESS) && (r_cnt != 2'd0)) || (r_state == S_RDLAST));
  assign w_lane  = (r_state == S_RDLAST) ? 2'd3 : (r_cnt - 2'd1);
  assign w_shift = {~w_lane, 3'b000};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_last_dbg  <= 1'b1;
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_done  <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_dbg_done  <= 1'b0;
      r_dbg_err   <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_cpu_err  <= 1'b0;
      r_dbg_done <= 1'b0;
      r_dbg_err  <= 1'b0;

      if (w_cap) begin
        if (r_id) r_dbg_rdata[w_shift +: 8] <= bus.mem_rdata;
        else      r_cpu_rdata[w_shift +: 8] <= bus.mem_rdata;
      end

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_id    <= w_gnt_dbg;
            r_we    <= w_we;
            r_word  <= w_addr[ADDR_W-1:2];
            r_wdata <= w_wdata;
            r_cnt   <= 2'd0;
            r_err   <= w_misaligned;
            if (w_misaligned) begin
              r_state    <= S_DONE;
              r_cpu_done <= ~w_gnt_dbg;
              r_cpu_err  <= ~w_gnt_dbg;
              r_dbg_done <= w_gnt_dbg;
              r_dbg_err  <= w_gnt_dbg;
            end else begin
              r_state     <= S_ACCESS;
              r_mem_en    <= 1'b1;
              r_mem_we    <= w_we;
              r_mem_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= w_wdata[31:24];
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 2'd3) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_we) begin
              r_state    <= S_DONE;
              r_cpu_done <= ~r_id;
              r_dbg_done <= r_id;
            end else begin
              r_state <= S_RDLAST;
            end
          end else begin
            r_cnt       <= w_cnt_inc;
            r_mem_addr  <= {r_word, w_cnt_inc};
            r_mem_wdata <= w_wbyte[w_cnt_inc];
          end
        end
        S_RDLAST: begin
          r_state    <= S_DONE;
          r_cpu_done <= ~r_id;
          r_dbg_done <= r_id;
        end
        S_DONE: begin
          r_last_dbg <= r_id;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_done  = r_cpu_done;
  assign bus.cpu_err   = r_cpu_err;
  assign bus.dbg_rdata = r_dbg_rdata;
  assign bus.dbg_done  = r_dbg_done;
  assign bus.dbg_err   = r_dbg_err;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous byte RAM.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_arbiter_if #(.ADDR_W(10)) bus ();
  dmem_arbiter #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] ram [1024];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  // Runs one transaction from C0; reports observations, compares nothing.
  task automatic issue(input bit dbg, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int done_cyc, output bit err,
                       output bit other_done, output logic [7:0] busy_mask, output int en_cnt);
    @(negedge clk);
    if (dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    done_cyc = -1; err = 1'b0; other_done = 1'b0; en_cnt = 0;
    busy_mask = 8'h00;
    busy_mask[0] = bus.busy;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k < 8) busy_mask[k] = bus.busy;
      if (bus.mem_en) en_cnt++;
      if (dbg ? bus.cpu_done : bus.dbg_done) other_done = 1'b1;
      if (dbg ? bus.dbg_done : bus.cpu_done) begin
        done_cyc = k;
        err = dbg ? bus.dbg_err : bus.cpu_err;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    $display("txn %s %s addr=%h wdata=%h done@C%0d err=%0d",
             dbg ? "dbg" : "cpu", we ? "st" : "ld", addr, wdata, done_cyc, err);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.mem_we, bus.busy, bus.cpu_done, bus.dbg_done, bus.cpu_err, bus.dbg_err} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000000",
                        {bus.mem_en, bus.mem_we, bus.busy, bus.cpu_done, bus.dbg_done, bus.cpu_err, bus.dbg_err});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h want all 0",
                        bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_store();
    int d; bit e; bit o; logic [7:0] bm; int en;
    issue(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, d, e, o, bm, en);
    n_cmp++; if (d !== 5) begin n_bad++; $display("FAIL store_done_cycle: got %0d want 5", d); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL store_err: got %b want 0", e); end
    n_cmp++; if (bm !== 8'b0011_1110) begin n_bad++; $display("FAIL store_busy: got %b want 00111110", bm); end
    n_cmp++; if (en !== 4) begin n_bad++; $display("FAIL store_en_cycles: got %0d want 4", en); end
    n_cmp++; if (o !== 1'b0) begin n_bad++; $display("FAIL store_dbg_done: got %b want 0", o); end
    n_cmp++;
    if ({ram[16], ram[17], ram[18], ram[19]} !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL store_ram: got %h want deadbeef", {ram[16], ram[17], ram[18], ram[19]});
    end
  endtask

  task automatic test_load();
    int d; bit e; bit o; logic [7:0] bm; int en;
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0, d, e, o, bm, en);
    n_cmp++; if (d !== 6) begin n_bad++; $display("FAIL load_done_cycle: got %0d want 6", d); end
    n_cmp++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_rdata: got %h want deadbeef", bus.cpu_rdata); end
    n_cmp++; if (o !== 1'b0) begin n_bad++; $display("FAIL load_dbg_done: got %b want 0", o); end
    n_cmp++; if (bm !== 8'b0111_1110) begin n_bad++; $display("FAIL load_busy: got %b want 01111110", bm); end
    n_cmp++; if (bus.dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL load_dbg_rdata: got %h want 0", bus.dbg_rdata); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_rdata_hold: got %h want deadbeef", bus.cpu_rdata); end
  endtask

  task automatic test_misaligned();
    int d; bit e; bit o; logic [7:0] bm; int en;
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, d, e, o, bm, en);
    n_cmp++; if (bus.dbg_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL dbg_load_rdata: got %h want deadbeef", bus.dbg_rdata); end
    issue(1'b1, 1'b0, 32'h0000_0022, 32'h0, d, e, o, bm, en);
    n_cmp++; if (d !== 1) begin n_bad++; $display("FAIL misal_done_cycle: got %0d want 1", d); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL misal_err: got %b want 1", e); end
    n_cmp++; if (en !== 0) begin n_bad++; $display("FAIL misal_mem_en: got %0d cycles want 0", en); end
    n_cmp++; if (bus.dbg_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL misal_rdata: got %h want deadbeef", bus.dbg_rdata); end
    n_cmp++; if (o !== 1'b0) begin n_bad++; $display("FAIL misal_cpu_done: got %b want 0", o); end
  endtask

  task automatic test_wrap();
    int d; bit e; bit o; logic [7:0] bm; int en;
    issue(1'b0, 1'b1, 32'h0000_0404, 32'h1122_3344, d, e, o, bm, en);
    n_cmp++;
    if ({ram[4], ram[5], ram[6], ram[7]} !== 32'h1122_3344) begin
      n_bad++; $display("FAIL wrap_ram: got %h want 11223344", {ram[4], ram[5], ram[6], ram[7]});
    end
    issue(1'b1, 1'b0, 32'h0000_0004, 32'h0, d, e, o, bm, en);
    n_cmp++; if (bus.dbg_rdata !== 32'h1122_3344) begin n_bad++; $display("FAIL wrap_readback: got %h want 11223344", bus.dbg_rdata); end
  endtask

  // Both requesters hold req for three transactions each; grant must alternate.
  task automatic test_back_to_back();
    int n_c = 0; int n_d = 0; int idx = 0; int both = 0;
    logic [5:0] glog = 6'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h300; bus.dbg_wdata = 32'hCAFE_F00D;
    for (int cyc = 0; cyc < 120 && (n_c < 3 || n_d < 3); cyc++) begin
      @(negedge clk);
      if (bus.cpu_done && bus.dbg_done) both++;
      if (bus.cpu_done) begin
        if (idx < 6) glog[idx] = 1'b0;
        idx++; n_c++;
        $display("txn cpu ld addr=00000010 grant#%0d rdata=%h", idx, bus.cpu_rdata);
        if (n_c == 3) bus.cpu_req = 1'b0;
      end
      if (bus.dbg_done) begin
        if (idx < 6) glog[idx] = 1'b1;
        idx++; n_d++;
        $display("txn dbg st addr=00000300 grant#%0d", idx);
        if (n_d == 3) bus.dbg_req = 1'b0;
      end
    end
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    n_cmp++; if (idx !== 6) begin n_bad++; $display("FAIL tie_count: got %0d grants want 6", idx); end
    n_cmp++; if (glog !== 6'b101010) begin n_bad++; $display("FAIL tie_order: got %b want 101010 (bit0 first, 1=dbg)", glog); end
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL tie_double_done: got %0d want 0", both); end
    n_cmp++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL tie_cpu_rdata: got %h want deadbeef", bus.cpu_rdata); end
    n_cmp++;
    if ({ram[768], ram[769], ram[770], ram[771]} !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL tie_dbg_ram: got %h want cafef00d", {ram[768], ram[769], ram[770], ram[771]});
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'hA1B2_C3D4;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 10'h042, 8'hC3}) begin
      n_bad++; $display("FAIL rstmid_c3: en=%b we=%b addr=%h wdata=%h want 1 1 042 c3",
                        bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    rst = 1'b0; bus.cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.mem_we, bus.busy, bus.cpu_done, bus.cpu_err} !== 5'b0) begin
      n_bad++; $display("FAIL rstmid_ctrl: got %b want 00000",
                        {bus.mem_en, bus.mem_we, bus.busy, bus.cpu_done, bus.cpu_err});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata} !== '0) begin
      n_bad++; $display("FAIL rstmid_data: addr=%h wdata=%h crd=%h drd=%h want all 0",
                        bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata);
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.cpu_done || bus.mem_en) seen++;
    end
    $display("txn cpu st addr=00000040 aborted by reset");
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_activity: got %0d cycles want 0", seen); end
    n_cmp++;
    if ({ram[64], ram[65], ram[66], ram[67]} !== 32'hA1B2_C300) begin
      n_bad++; $display("FAIL rstmid_ram: got %h want a1b2c300", {ram[64], ram[65], ram[66], ram[67]});
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
